vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/pixel_tick_gen.sv | 34 +++
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing defaults, derived sync windows and the coordinate type
// used by both the sync generator and the downstream text generator.
package vga_timing_pkg;

   localparam int unsigned H_DISPLAY_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_DISPLAY_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;
   localparam int unsigned TICK_DIV_DEF  = 4;

   localparam int unsigned H_TOTAL  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int unsigned HS_START = H_DISPLAY_DEF + H_FRONT_DEF;
   localparam int unsigned HS_END   = HS_START + H_SYNC_DEF - 1;
   localparam int unsigned VS_START = V_DISPLAY_DEF + V_FRONT_DEF;
   localparam int unsigned VS_END   = VS_START + V_SYNC_DEF - 1;

   typedef logic [9:0] coord_t;

   // Inclusive window test on a screen coordinate.
   function automatic logic in_window(input coord_t v, input int unsigned lo,
                                      input int unsigned hi);
      return (32'(v) >= lo) && (32'(v) <= hi);
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: free-running divider plus a registered one-clk p_tick pulse.
// o_tick_next is high on the clk whose rising edge raises o_tick.
module pixel_tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick,
   output logic o_tick_next
);

   localparam int unsigned   DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

   logic [DivW-1:0] r_div;
   logic            r_tick;
   logic            w_last;

   assign w_last = (r_div == DivLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= w_last ? '0 : r_div + DivW'(1);
         r_tick <= w_last;
      end
   end

   assign o_tick      = r_tick;
   assign o_tick_next = w_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync and blanking outputs.
// Define VGA_SYNC_FRAME_CNT_EN to add the frame_cnt / frame_start outputs.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF,
   parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt,
   output logic       frame_start
`endif
);

   localparam int unsigned HTotal  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned VTotal  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HsStart = H_DISPLAY + H_FRONT;
   localparam int unsigned HsEnd   = HsStart + H_SYNC - 1;
   localparam int unsigned VsStart = V_DISPLAY + V_FRONT;
   localparam int unsigned VsEnd   = VsStart + V_SYNC - 1;

   logic   w_tick;
   logic   w_adv;
   logic   w_h_end;
   logic   w_v_end;
   coord_t w_x_next;
   coord_t w_y_next;
   coord_t r_x;
   coord_t r_y;
   logic   r_video_on;
   logic   r_hsync;
   logic   r_vsync;

   pixel_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk         (clk),
      .reset       (reset),
      .o_tick      (w_tick),
      .o_tick_next (w_adv)
   );

   // Counters step on the same edge that raises p_tick, so every output moves together.
   always_comb begin
      w_h_end  = (r_x == coord_t'(HTotal - 1));
      w_v_end  = (r_y == coord_t'(VTotal - 1));
      w_x_next = r_x;
      w_y_next = r_y;
      if (w_adv) begin
         w_x_next = w_h_end ? '0 : r_x + coord_t'(1);
         if (w_h_end) begin
            w_y_next = w_v_end ? '0 : r_y + coord_t'(1);
         end
      end
   end

   // Sync and blanking are decoded from next-state counts so they line up with pixel_x/y.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x        <= '0;
         r_y        <= '0;
         r_video_on <= 1'b0;
         r_hsync    <= 1'b1;
         r_vsync    <= 1'b1;
      end else begin
         r_x        <= w_x_next;
         r_y        <= w_y_next;
         r_video_on <= (32'(w_x_next) < H_DISPLAY) && (32'(w_y_next) < V_DISPLAY);
         r_hsync    <= ~in_window(w_x_next, HsStart, HsEnd);
         r_vsync    <= ~in_window(w_y_next, VsStart, VsEnd);
      end
   end

   assign p_tick   = w_tick;
   assign pixel_x  = r_x;
   assign pixel_y  = r_y;
   assign video_on = r_video_on;
   assign hsync    = r_hsync;
   assign vsync    = r_vsync;

`ifdef VGA_SYNC_FRAME_CNT_EN
   logic       w_frame_wrap;
   logic [7:0] r_frame_cnt;
   logic       r_frame_start;

   assign w_frame_wrap = w_adv & w_h_end & w_v_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_cnt   <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_wrap;
         if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign frame_cnt   = r_frame_cnt;
   assign frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a tiny-timing instance checked every clk
// against a closed-form model of clocks-since-reset; random reset points and lengths.
module tb_vga_sync_gen;

   localparam int S_HD = 3, S_HF = 1, S_HS = 2, S_HB = 1;
   localparam int S_VD = 2, S_VF = 1, S_VS = 2, S_VB = 1;
   localparam int S_FRAME = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB) * 4;
   localparam int D_RUN   = 257 * S_FRAME + 8;

   typedef struct {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       hs;
      logic       vs;
      logic       fst;
      logic [7:0] fcnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       d_tick, d_von, d_hs, d_vs;
   logic [9:0] d_x, d_y;
   logic       s_tick, s_von, s_hs, s_vs;
   logic [9:0] s_x, s_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] d_fcnt, s_fcnt;
   logic       d_fst, s_fst;
   int         fst_k[$];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;
   int tick_cnt, hs_low, vs_low, line_k, prev_dx;

   always #5 clk = ~clk;

   vga_sync_gen u_dut (
      .clk      (clk),
      .reset    (rst),
      .p_tick   (d_tick),
      .pixel_x  (d_x),
      .pixel_y  (d_y),
      .video_on (d_von),
      .hsync    (d_hs),
      .vsync    (d_vs)
`ifdef VGA_SYNC_FRAME_CNT_EN
      ,
      .frame_cnt   (d_fcnt),
      .frame_start (d_fst)
`endif
   );

   vga_sync_gen #(
      .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
      .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
      .TICK_DIV  (4)
   ) u_small (
      .clk      (clk),
      .reset    (rst),
      .p_tick   (s_tick),
      .pixel_x  (s_x),
      .pixel_y  (s_y),
      .video_on (s_von),
      .hsync    (s_hs),
      .vsync    (s_vs)
`ifdef VGA_SYNC_FRAME_CNT_EN
      ,
      .frame_cnt   (s_fcnt),
      .frame_start (s_fst)
`endif
   );

   // Expected outputs kk clock edges after reset release: pixel index is kk/4.
   function automatic exp_t model(input int kk, input bit in_rst, input int hd, input int hf,
                                  input int hsw, input int hb, input int vd, input int vf,
                                  input int vsw, input int vb);
      exp_t e;
      int ht, vt, p, x, y;
      ht     = hd + hf + hsw + hb;
      vt     = vd + vf + vsw + vb;
      e.tick = 1'b0;
      e.x    = '0;
      e.y    = '0;
      e.von  = 1'b0;
      e.hs   = 1'b1;
      e.vs   = 1'b1;
      e.fst  = 1'b0;
      e.fcnt = '0;
      if (in_rst || kk == 0) return e;
      p      = kk / 4;
      x      = p % ht;
      y      = (p / ht) % vt;
      e.tick = (kk % 4 == 0);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.von  = (x < hd) && (y < vd);
      e.hs   = !((x >= hd + hf) && (x < hd + hf + hsw));
      e.vs   = !((y >= vd + vf) && (y < vd + vf + vsw));
      e.fst  = e.tick && (p % (ht * vt) == 0);
      e.fcnt = 8'((p / (ht * vt)) % 256);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, exp, k);
      end
   endtask

   task automatic check_all(input bit in_rst);
      exp_t e;
      e = model(k, in_rst, 640, 16, 96, 48, 480, 10, 2, 33);
      chk("d.p_tick", d_tick, e.tick);
      chk("d.pixel_x", d_x, e.x);
      chk("d.pixel_y", d_y, e.y);
      chk("d.video_on", d_von, e.von);
      chk("d.hsync", d_hs, e.hs);
      chk("d.vsync", d_vs, e.vs);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("d.frame_start", d_fst, e.fst);
      chk("d.frame_cnt", d_fcnt, e.fcnt);
`endif
      e = model(k, in_rst, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
      chk("s.p_tick", s_tick, e.tick);
      chk("s.pixel_x", s_x, e.x);
      chk("s.pixel_y", s_y, e.y);
      chk("s.video_on", s_von, e.von);
      chk("s.hsync", s_hs, e.hs);
      chk("s.vsync", s_vs, e.vs);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("s.frame_start", s_fst, e.fst);
      chk("s.frame_cnt", s_fcnt, e.fcnt);
`endif
   endtask

   task automatic clear_obs();
      tick_cnt = 0;
      hs_low   = 0;
      vs_low   = 0;
      line_k   = -1;
      prev_dx  = 0;
`ifdef VGA_SYNC_FRAME_CNT_EN
      fst_k.delete();
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         k++;
         check_all(1'b0);
         if (d_tick === 1'b1) tick_cnt++;
         if (d_hs === 1'b0 && k < 3200) hs_low++;
         if (s_vs === 1'b0 && k < S_FRAME) vs_low++;
         if (line_k < 0 && prev_dx == 799 && d_x == 10'd0) line_k = k;
         prev_dx = int'(d_x);
`ifdef VGA_SYNC_FRAME_CNT_EN
         if (s_fst === 1'b1) fst_k.push_back(k);
`endif
      end
   endtask

   // Reset lands mid-cycle to exercise the asynchronous path; release is on a falling edge.
   task automatic do_reset(input int hold);
      @(posedge clk);
      #($urandom_range(2, 4));
      rst = 1'b1;
      #1;
      check_all(1'b1);
      repeat (hold) begin
         @(posedge clk);
         #1;
         check_all(1'b1);
      end
      @(negedge clk);
      rst = 1'b0;
      k   = 0;
      clear_obs();
      #1;
      check_all(1'b0);
   endtask

   initial begin
      clear_obs();
      do_reset(2);

      run(40);
      chk("p_tick_pulses_first_40", tick_cnt, 10);

      run(3300 - 40);
      chk("hsync_low_clks_line0", hs_low, 384);
      chk("line_wrap_clk", line_k, 3200);

      for (int r = 0; r < 4; r++) begin
         run(int'($urandom_range(50, 1500)));
         do_reset((r == 0) ? 3 : int'($urandom_range(1, 5)));
         run(4);
         chk("p_tick_after_reset", tick_cnt, 1);
      end

      do_reset(2);
      run(D_RUN);
      chk("vsync_low_clks_frame0", vs_low, 56);
      chk("p_tick_pulses_frames", tick_cnt, D_RUN / 4);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("frame_start_count", fst_k.size(), 257);
      chk("frame_start_first", (fst_k.size() > 0) ? fst_k[0] : -1, S_FRAME);
      chk("frame_start_gap1", (fst_k.size() > 1) ? fst_k[1] - fst_k[0] : -1, S_FRAME);
      chk("frame_start_gap2", (fst_k.size() > 2) ? fst_k[2] - fst_k[1] : -1, S_FRAME);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
